memory_cell_ttl: RTL and testbench

Parametrised successor to the basic key/value storage cell. Holds one key/value entry with an explicit valid flag and an optional time-to-live countdown. The entry expires autonomously when its TTL reaches zero. Instantiated N times inside the cache memory array; the array controller drives op strobes and a shared TTL tick.

---
 rtl/memory_cell_ttl.sv | 109 ++++++++++
 tb/tb_memory_cell_ttl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_cell_ttl.sv
// Single key/value cache entry with a valid flag and an optional time-to-live
// countdown that expires the entry on its own when the count runs out.
module memory_cell_ttl #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter bit TTL_ENABLE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_in,
  input  logic                   write_op,
  input  logic                   delete_op,
  input  logic                   touch_op,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic [TTL_WIDTH-1:0]   ttl_in,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [TTL_WIDTH-1:0]   ttl_out,
  output logic                   used_out,
  output logic                   match_out,
  output logic                   expired_out,
  output logic [1:0]             state_out
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PERSIST = 2'd1,
    ST_TIMED   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [TTL_WIDTH-1:0]   ttl_q, ttl_d;
  logic                   expired_q, expired_d;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_EMPTY;
      key_q     <= '0;
      value_q   <= '0;
      ttl_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      value_q   <= value_d;
      ttl_q     <= ttl_d;
      expired_q <= expired_d;
    end
  end

  // One action per cycle: delete > write > touch > tick.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    value_d   = value_q;
    ttl_d     = ttl_q;
    expired_d = 1'b0;
    if (delete_op) begin
      state_d = ST_EMPTY;
      key_d   = '0;
      value_d = '0;
      ttl_d   = '0;
    end else if (write_op) begin
      key_d   = key_in;
      value_d = value_in;
      if (TTL_ENABLE && (ttl_in != '0)) begin
        state_d = ST_TIMED;
        ttl_d   = ttl_in;
      end else begin
        state_d = ST_PERSIST;
        ttl_d   = '0;
      end
    end else if (touch_op && TTL_ENABLE && (state_q != ST_EMPTY)) begin
      if (ttl_in != '0) begin
        state_d = ST_TIMED;
        ttl_d   = ttl_in;
      end else begin
        state_d = ST_PERSIST;
        ttl_d   = '0;
      end
    end else if (tick_in && TTL_ENABLE && (state_q == ST_TIMED)) begin
      if (ttl_q == TTL_WIDTH'(1)) begin
        state_d   = ST_EMPTY;
        key_d     = '0;
        value_d   = '0;
        ttl_d     = '0;
        expired_d = 1'b1;
      end else begin
        ttl_d = ttl_q - TTL_WIDTH'(1);
      end
    end
  end

  always_comb begin
    key_out     = key_q;
    value_out   = value_q;
    ttl_out     = TTL_ENABLE ? ttl_q : '0;
    used_out    = (state_q != ST_EMPTY);
    match_out   = (state_q != ST_EMPTY) && (key_q == key_in);
    expired_out = TTL_ENABLE ? expired_q : 1'b0;
    state_out   = state_q;
  end

endmodule

// File: tb/tb_memory_cell_ttl.sv
// Scoreboard bench for memory_cell_ttl: a TTL-enabled cell and a TTL-disabled
// cell share stimulus; a reference model predicts both cells each cycle.
module tb_memory_cell_ttl;

  localparam int KW = 8;
  localparam int VW = 64;
  localparam int TW = 32;
  localparam int CW = 1 + KW + VW + TW + 1 + 1 + 1; // used,key,val,ttl,exp,match,nonempty
  localparam int EW = 2 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b0, write_op = 1'b0, delete_op = 1'b0, touch_op = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic [VW-1:0] value_in = '0;
  logic [TW-1:0] ttl_in = '0;

  logic [KW-1:0] a_key, b_key;
  logic [VW-1:0] a_val, b_val;
  logic [TW-1:0] a_ttl, b_ttl;
  logic          a_used, b_used, a_match, b_match, a_exp, b_exp;
  logic [1:0]    a_st, b_st;

  memory_cell_ttl #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .TTL_ENABLE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst), .tick_in(tick_in), .write_op(write_op), .delete_op(delete_op),
    .touch_op(touch_op), .key_in(key_in), .value_in(value_in), .ttl_in(ttl_in),
    .key_out(a_key), .value_out(a_val), .ttl_out(a_ttl), .used_out(a_used),
    .match_out(a_match), .expired_out(a_exp), .state_out(a_st)
  );

  memory_cell_ttl #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .TTL_ENABLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst), .tick_in(tick_in), .write_op(write_op), .delete_op(delete_op),
    .touch_op(touch_op), .key_in(key_in), .value_in(value_in), .ttl_in(ttl_in),
    .key_out(b_key), .value_out(b_val), .ttl_out(b_ttl), .used_out(b_used),
    .match_out(b_match), .expired_out(b_exp), .state_out(b_st)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Entry A: ttl 0 means persistent. Entry B never counts.
  logic          ma_used, mb_used, ma_exp;
  logic [KW-1:0] ma_key, mb_key;
  logic [VW-1:0] ma_val, mb_val;
  logic [TW-1:0] ma_ttl;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_clear();
    ma_used = 0; ma_key = '0; ma_val = '0; ma_ttl = '0; ma_exp = 0;
    mb_used = 0; mb_key = '0; mb_val = '0;
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [KW-1:0] k);
    logic ma_match, mb_match;
    ma_match = ma_used && (ma_key == k);
    mb_match = mb_used && (mb_key == k);
    return {ma_used, ma_key, ma_val, ma_ttl, ma_exp, ma_match, ma_used,
            mb_used, mb_key, mb_val, {TW{1'b0}}, 1'b0, mb_match, mb_used};
  endfunction

  function automatic logic [EW-1:0] pack_act();
    return {a_used, a_key, a_val, a_ttl, a_exp, a_match, (a_st != 2'd0),
            b_used, b_key, b_val, b_ttl, b_exp, b_match, (b_st != 2'd0)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic del, input logic wr, input logic tch, input logic tck,
                      input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [TW-1:0] t);
    @(negedge clk);
    delete_op = del; write_op = wr; touch_op = tch; tick_in = tck;
    key_in = k; value_in = v; ttl_in = t;
    ma_exp = 0;
    if (del) begin
      model_clear();
    end else if (wr) begin
      ma_used = 1; ma_key = k; ma_val = v; ma_ttl = t;
      mb_used = 1; mb_key = k; mb_val = v;
    end else if (tch && ma_used) begin
      ma_ttl = t;
    end else if (tck && ma_used && ma_ttl != 0) begin
      if (ma_ttl == 1) begin
        ma_used = 0; ma_key = '0; ma_val = '0; ma_ttl = '0; ma_exp = 1;
      end else begin
        ma_ttl = ma_ttl - 1;
      end
    end
    exp_q.push_back(pack_exp(k));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, key_in, '0, '0);
  endtask

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      e = exp_q.pop_front();
      a = pack_act();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_state t=%0t: got %h required %h", $time, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [KW-1:0] keys[4];
    model_clear();
    #2;
    check("reset_used", {63'b0, a_used}, '0);
    check("reset_key", {56'b0, a_key}, '0);
    check("reset_ttl", {32'b0, a_ttl}, '0);
    check("reset_exp", {63'b0, a_exp}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // persistent entry with key 0 survives ticks
    step(0, 1, 0, 0, 8'h00, 64'hDEAD_BEEF, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 8'h00, '0, '0);

    // countdown 3,2,1 then expiry pulse
    step(0, 1, 0, 0, 8'h2A, 64'h1234, 3);
    repeat (3) step(0, 0, 0, 1, 8'h2A, '0, '0);
    idle(2);

    // touch rescues an expiring entry, then makes it persistent
    step(0, 1, 0, 0, 8'h33, 64'h55, 2);
    step(0, 0, 0, 1, 8'h33, '0, '0);
    step(0, 0, 1, 1, 8'h33, '0, 5);
    step(0, 0, 0, 1, 8'h33, '0, '0);
    step(0, 0, 1, 0, 8'h33, '0, 0);
    repeat (8) step(0, 0, 0, 1, 8'h33, '0, '0);

    // delete wins over write
    step(0, 0, 0, 0, 8'h2A, '0, '0);
    step(1, 1, 0, 0, 8'h44, 64'h99, 7);
    idle(1);

    // write wins over an expiring tick
    step(0, 1, 0, 0, 8'h10, 64'h7, 1);
    step(0, 1, 0, 1, 8'h11, 64'h8, 4);
    repeat (5) step(0, 0, 0, 1, 8'h11, '0, '0);

    // match follows key_in combinationally, drops after delete
    step(0, 1, 0, 0, 8'h2A, 64'hAB, 0);
    step(0, 0, 0, 0, 8'h2A, '0, '0);
    step(0, 0, 0, 0, 8'h2B, '0, '0);
    step(1, 0, 0, 0, 8'h2A, '0, '0);
    // touch on an empty entry is ignored
    step(0, 0, 1, 0, 8'h2A, '0, 6);
    step(0, 0, 0, 1, 8'h2A, '0, '0);

    // randomized mix
    keys[0] = 8'h00; keys[1] = 8'h2A; keys[2] = 8'h11; keys[3] = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      logic [KW-1:0] k;
      k = ($urandom_range(0, 3) == 0) ? KW'($urandom) : keys[$urandom_range(0, 3)];
      step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           k, {$urandom, $urandom}, TW'($urandom_range(0, 4)));
    end

    // asynchronous reset mid-countdown
    step(0, 1, 0, 0, 8'h2A, 64'hCAFE, 9);
    step(0, 0, 0, 1, 8'h2A, '0, '0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    delete_op = 0; write_op = 0; touch_op = 0; tick_in = 0;
    #1;
    check("async_rst_used", {63'b0, a_used}, '0);
    check("async_rst_key", {56'b0, a_key}, '0);
    check("async_rst_val", a_val, '0);
    check("async_rst_ttl", {32'b0, a_ttl}, '0);
    check("async_rst_b_used", {63'b0, b_used}, '0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 8'h5A, 64'h1, 2);
    repeat (3) step(0, 0, 0, 1, 8'h5A, '0, '0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
